// File: rtl/map_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : map_pkg
//  Description : Shared constants for scroll_tile_map: lane palette, the
//                per-lane modulo rules, block-state codes and the FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package map_pkg;

    localparam int PAT_N      = 5;
    localparam int ST_EMPTY   = 0;
    localparam int ST_BLOCK   = 1;
    localparam int ST_SPECIAL = 2;

    localparam logic [11:0] PALETTE [PAT_N] = '{12'hF00, 12'h0F0, 12'h00F, 12'h0FF, 12'hF0F};
    localparam logic [3:0]  MA      [PAT_N] = '{4'd3,  4'd5,  4'd4, 4'd6, 4'd7};
    localparam logic [3:0]  OA      [PAT_N] = '{4'd1,  4'd0,  4'd2, 4'd4, 4'd2};
    localparam logic [3:0]  MB      [PAT_N] = '{4'd10, 4'd12, 4'd8, 4'd9, 4'd14};
    localparam logic [3:0]  OB      [PAT_N] = '{4'd0,  4'd3,  4'd0, 4'd6, 4'd4};

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        READY = 2'd1,
        REGEN = 2'd2
    } fsm_e;

    // Index width that stays legal for a single-entry dimension.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scroll_tile_map_if.sv
`default_nettype none
// ============================================================================
//  Module      : scroll_tile_map_if
//  Description : Read / write / scroll bundle between the game engine and
//                renderer (master) and the tile-map store (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface scroll_tile_map_if
    import map_pkg::*;
#(
    parameter int LANES   = 5,
    parameter int COLS    = 100,
    parameter int STATE_W = 3,
    parameter int GCOL_W  = 16
);
    localparam int LW = idx_w(LANES);
    localparam int CW = idx_w(COLS);

    logic               rd_en;
    logic [LW-1:0]      rd_lane;
    logic [CW-1:0]      rd_col;
    logic               rd_valid;
    logic [3:0]         r;
    logic [3:0]         g;
    logic [3:0]         b;
    logic [STATE_W-1:0] block_state;
    logic               wr_en;
    logic               wr_ready;
    logic [LW-1:0]      wr_lane;
    logic [CW-1:0]      wr_col;
    logic [STATE_W-1:0] wr_state;
    logic               scroll_req;
    logic               scroll_ack;
    logic               busy;
    logic               map_ready;
    logic [GCOL_W-1:0]  gen_col;

    modport master (
        output rd_en, rd_lane, rd_col, wr_en, wr_lane, wr_col, wr_state, scroll_req,
        input  rd_valid, r, g, b, block_state, wr_ready, scroll_ack, busy, map_ready, gen_col
    );

    modport slave (
        input  rd_en, rd_lane, rd_col, wr_en, wr_lane, wr_col, wr_state, scroll_req,
        output rd_valid, r, g, b, block_state, wr_ready, scroll_ack, busy, map_ready, gen_col
    );

endinterface
`default_nettype wire

// File: rtl/lane_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lane_pattern_gen
//  Description : Per-lane residue counters of the generated column; yields
//                the {state, colour} word for the selected lane. Counters
//                step once per completed column, so no dividers are needed.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_pattern_gen
    import map_pkg::*;
#(
    parameter  int LANES   = 5,
    parameter  int STATE_W = 3,
    localparam int LW      = idx_w(LANES)
) (
    input  wire                  clk,
    input  wire                  rst_n,
    input  wire                  advance_i,
    input  wire  [LW-1:0]        lane_i,
    output logic [STATE_W+11:0]  word_o
);

    logic [STATE_W-1:0] state_w  [LANES];
    logic [11:0]        colour_w [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int T = i % PAT_N;
        logic [3:0] ra_q;
        logic [3:0] rb_q;

        // Track g mod MA and g mod MB for this lane; wraps independently of gen_col.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ra_q <= '0;
                rb_q <= '0;
            end else if (advance_i) begin
                ra_q <= (ra_q == MA[T] - 4'd1) ? '0 : ra_q + 4'd1;
                rb_q <= (rb_q == MB[T] - 4'd1) ? '0 : rb_q + 4'd1;
            end
        end

        assign colour_w[i] = PALETTE[T];
        assign state_w[i]  = (ra_q == OA[T]) ? STATE_W'(ST_EMPTY)   :
                             (rb_q == OB[T]) ? STATE_W'(ST_SPECIAL) :
                                               STATE_W'(ST_BLOCK);
    end

    assign word_o = {state_w[lane_i], colour_w[lane_i]};

endmodule
`default_nettype wire

// File: rtl/scroll_tile_map.sv
`default_nettype none
// ============================================================================
//  Module      : scroll_tile_map
//  Description : Scrollable LANES x COLS tile-map store. Self-fills after
//                reset, regenerates the departing column on each scroll,
//                accepts block-state overwrites, registered read port.
//  Options     : MAP_RD_BYPASS_EN - forward a same-cycle write to the read.
//  Revision    : 1.0 - initial release
// ============================================================================
module scroll_tile_map
    import map_pkg::*;
#(
    parameter int LANES   = 5,
    parameter int COLS    = 100,
    parameter int STATE_W = 3,
    parameter int GCOL_W  = 16
) (
    input wire               clk,
    input wire               rst_n,
    scroll_tile_map_if.slave bus
);

    localparam int LW = idx_w(LANES);
    localparam int CW = idx_w(COLS);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
    localparam logic [LW:0]   LANES_X   = (LW+1)'(LANES);
    localparam logic [CW:0]   COLS_X    = (CW+1)'(COLS);

    fsm_e                state_q, state_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic [CW-1:0]       col_q, col_d;
    logic [CW-1:0]       base_q, base_d;
    logic [GCOL_W-1:0]   gen_col_q, gen_col_d;
    logic                map_ready_q, map_ready_d;
    logic                scroll_ack_q, scroll_ack_d;
    logic                gen_we, gen_adv;
    logic [CW-1:0]       gen_phys;
    logic [STATE_W+11:0] gen_word;

    logic [11:0]         colour_mem [LANES][COLS];
    logic [STATE_W-1:0]  state_mem  [LANES][COLS];

    logic                rd_valid_q;
    logic [11:0]         rgb_q;
    logic [STATE_W-1:0]  bs_q;

    // Logical-to-physical column: one add and one conditional subtract.
    logic [CW:0]   rd_sum, wr_sum;
    logic [CW-1:0] rd_phys, wr_phys;
    logic          rd_oor, wr_oor, wr_acc;

    assign rd_sum  = {1'b0, base_q} + {1'b0, bus.rd_col};
    assign wr_sum  = {1'b0, base_q} + {1'b0, bus.wr_col};
    assign rd_phys = (rd_sum >= COLS_X) ? CW'(rd_sum - COLS_X) : rd_sum[CW-1:0];
    assign wr_phys = (wr_sum >= COLS_X) ? CW'(wr_sum - COLS_X) : wr_sum[CW-1:0];
    assign rd_oor  = ({1'b0, bus.rd_lane} >= LANES_X) || ({1'b0, bus.rd_col} >= COLS_X);
    assign wr_oor  = ({1'b0, bus.wr_lane} >= LANES_X) || ({1'b0, bus.wr_col} >= COLS_X);
    assign wr_acc  = bus.wr_en && (state_q == READY) && !wr_oor;

    lane_pattern_gen #(
        .LANES   (LANES),
        .STATE_W (STATE_W)
    ) u_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance_i (gen_adv),
        .lane_i    (lane_q),
        .word_o    (gen_word)
    );

    // Control registers; reset aborts any fill or regen and restarts INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT;
            lane_q       <= '0;
            col_q        <= '0;
            base_q       <= '0;
            gen_col_q    <= '0;
            map_ready_q  <= 1'b0;
            scroll_ack_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            col_q        <= col_d;
            base_q       <= base_d;
            gen_col_q    <= gen_col_d;
            map_ready_q  <= map_ready_d;
            scroll_ack_q <= scroll_ack_d;
        end
    end

    // Next state: column-major fill in INIT, one lane per cycle in REGEN.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        col_d        = col_q;
        base_d       = base_q;
        gen_col_d    = gen_col_q;
        map_ready_d  = map_ready_q;
        scroll_ack_d = 1'b0;
        gen_we       = 1'b0;
        gen_adv      = 1'b0;
        gen_phys     = col_q;
        case (state_q)
            INIT: begin
                gen_we = 1'b1;
                if (lane_q == LAST_LANE) begin
                    lane_d  = '0;
                    gen_adv = 1'b1;
                    if (col_q == LAST_COL) begin
                        col_d       = '0;
                        state_d     = READY;
                        map_ready_d = 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            READY: begin
                if (bus.scroll_req) begin
                    state_d      = REGEN;
                    scroll_ack_d = 1'b1;
                    lane_d       = '0;
                end
            end
            REGEN: begin
                gen_we   = 1'b1;
                gen_phys = base_q;
                if (lane_q == LAST_LANE) begin
                    lane_d    = '0;
                    gen_adv   = 1'b1;
                    state_d   = READY;
                    base_d    = (base_q == LAST_COL) ? '0 : base_q + 1'b1;
                    gen_col_d = gen_col_q + 1'b1;
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Cell storage: generator owns INIT/REGEN, engine writes only in READY.
    always_ff @(posedge clk) begin
        if (gen_we) begin
            colour_mem[lane_q][gen_phys] <= gen_word[11:0];
            state_mem[lane_q][gen_phys]  <= gen_word[STATE_W+11:12];
        end else if (wr_acc) begin
            state_mem[bus.wr_lane][wr_phys] <= bus.wr_state;
        end
    end

    // Registered read port; data holds whenever no read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rgb_q      <= '0;
            bs_q       <= '0;
        end else if (bus.rd_en && map_ready_q) begin
            rd_valid_q <= 1'b1;
            if (rd_oor) begin
                rgb_q <= '0;
                bs_q  <= '0;
            end else begin
                rgb_q <= colour_mem[bus.rd_lane][rd_phys];
                bs_q  <= state_mem[bus.rd_lane][rd_phys];
`ifdef MAP_RD_BYPASS_EN
                if (wr_acc && (bus.wr_lane == bus.rd_lane) && (bus.wr_col == bus.rd_col))
                    bs_q <= bus.wr_state;
`endif
            end
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

    assign bus.rd_valid    = rd_valid_q;
    assign bus.r           = rgb_q[11:8];
    assign bus.g           = rgb_q[7:4];
    assign bus.b           = rgb_q[3:0];
    assign bus.block_state = bs_q;
    assign bus.wr_ready    = (state_q == READY);
    assign bus.scroll_ack  = scroll_ack_q;
    assign bus.busy        = (state_q != READY);
    assign bus.map_ready   = map_ready_q;
    assign bus.gen_col     = gen_col_q;

endmodule
`default_nettype wire

// File: tb/tb_scroll_tile_map.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scroll_tile_map
//  Description : Self-checking bench for scroll_tile_map; read results are
//                predicted from an independent modulo model and checked
//                through a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scroll_tile_map;

    localparam int LW = 3;
    localparam int CW = 7;
    localparam int MA_T [5] = '{3, 5, 4, 6, 7};
    localparam int OA_T [5] = '{1, 0, 2, 4, 2};
    localparam int MB_T [5] = '{10, 12, 8, 9, 14};
    localparam int OB_T [5] = '{0, 3, 0, 6, 4};
    localparam logic [11:0] PAL_T [5] = '{12'hF00, 12'h0F0, 12'h00F, 12'h0FF, 12'hF0F};

    typedef struct {
        int          due;
        int          id;
        logic        v;
        logic [11:0] rgb;
        logic [2:0]  st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   vec = 0;
    int   err = 0;
    int   cyc = 0;
    int   rd_id = 0;
    int   gm = 0;
    logic mready = 1'b0;
    exp_t sb [$];

    scroll_tile_map_if #(.LANES(5), .COLS(100), .STATE_W(3), .GCOL_W(16)) bus ();

    scroll_tile_map #(.LANES(5), .COLS(100), .STATE_W(3), .GCOL_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model_state(int lane, int g);
        int t = lane % 5;
        if ((g % MA_T[t]) == OA_T[t]) return 3'd0;
        if ((g % MB_T[t]) == OB_T[t]) return 3'd2;
        return 3'd1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a read for the coming edge and queue what it must return.
    task automatic push_read(int lane, int col, int st_override);
        exp_t e;
        bus.rd_en   = 1'b1;
        bus.rd_lane = LW'(lane);
        bus.rd_col  = CW'(col);
        e.due = cyc + 1;
        e.id  = rd_id;
        e.v   = mready;
        if (lane >= 5 || col >= 100) begin
            e.rgb = '0;
            e.st  = '0;
        end else begin
            e.rgb = PAL_T[lane % 5];
            e.st  = (st_override >= 0) ? 3'(st_override) : model_state(lane, gm + col);
        end
        rd_id++;
        sb.push_back(e);
    endtask

    task automatic do_read(int lane, int col, int st_override);
        push_read(lane, col, st_override);
        step();
        bus.rd_en = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                vec++; err++;
                $display("FAIL read#%0d: result never sampled (due %0d, now %0d)", e.id, e.due, cyc);
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                vec++;
                if (bus.rd_valid !== e.v ||
                    (e.v && ({bus.r, bus.g, bus.b} !== e.rgb || bus.block_state !== e.st))) begin
                    err++;
                    $display("FAIL read#%0d: got valid=%b rgb=%h state=%0d, want valid=%b rgb=%h state=%0d",
                             e.id, bus.rd_valid, {bus.r, bus.g, bus.b}, bus.block_state, e.v, e.rgb, e.st);
                end
            end else if (bus.rd_valid === 1'b1) begin
                vec++; err++;
                $display("FAIL spurious_rd_valid: got 1 at cycle %0d, want 0", cyc);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) step();
        vec++; if (bus.rd_valid !== 1'b0) begin err++; $display("FAIL rst_rd_valid: got %b want 0", bus.rd_valid); end
        vec++; if (bus.scroll_ack !== 1'b0) begin err++; $display("FAIL rst_scroll_ack: got %b want 0", bus.scroll_ack); end
        vec++; if (bus.wr_ready !== 1'b0) begin err++; $display("FAIL rst_wr_ready: got %b want 0", bus.wr_ready); end
        vec++; if (bus.map_ready !== 1'b0) begin err++; $display("FAIL rst_map_ready: got %b want 0", bus.map_ready); end
        vec++; if (bus.busy !== 1'b1) begin err++; $display("FAIL rst_busy: got %b want 1", bus.busy); end
        vec++; if ({bus.r, bus.g, bus.b, bus.block_state} !== 15'd0) begin err++;
            $display("FAIL rst_data: got %h want 0", {bus.r, bus.g, bus.b, bus.block_state}); end
        vec++; if (bus.gen_col !== 16'd0) begin err++; $display("FAIL rst_gen_col: got %0d want 0", bus.gen_col); end
    endtask

    // Release reset and count edges until map_ready; reads/scrolls meanwhile are ignored.
    task automatic run_init(string tag);
        int   cnt = 0;
        logic busy_dropped = 1'b0;
        rst_n = 1'b1;
        mready = 1'b0;
        gm = 0;
        push_read(0, 0, -1);
        bus.scroll_req = 1'b1;
        while (bus.map_ready !== 1'b1 && cnt < 600) begin
            step();
            cnt++;
            bus.rd_en = 1'b0;
            bus.scroll_req = 1'b0;
            if (bus.map_ready !== 1'b1 && bus.busy !== 1'b1) busy_dropped = 1'b1;
        end
        mready = 1'b1;
        vec++; if (cnt != 500) begin err++; $display("FAIL %s_cycles: got %0d want 500", tag, cnt); end
        vec++; if (busy_dropped !== 1'b0) begin err++; $display("FAIL %s_busy: got low during fill want high", tag); end
        vec++; if (bus.busy !== 1'b0 || bus.wr_ready !== 1'b1) begin err++;
            $display("FAIL %s_ready: got busy=%b wr_ready=%b want 0/1", tag, bus.busy, bus.wr_ready); end
        vec++; if (bus.gen_col !== 16'd0) begin err++; $display("FAIL %s_gen_col: got %0d want 0", tag, bus.gen_col); end
    endtask

    task automatic test_init();
        run_init("init");
    endtask

    task automatic test_reads();
        do_read(0, 0, -1);
        do_read(0, 1, -1);
        do_read(1, 3, -1);
        do_read(4, 50, -1);
        do_read(3, 99, -1);
        do_read(5, 0, -1);
        do_read(2, 127, -1);
        step();
    endtask

    // Accept a scroll and measure ack/busy; returns with the FSM back in READY.
    task automatic scroll_once(string tag);
        int n = 1;
        bus.scroll_req = 1'b1;
        step();
        bus.scroll_req = 1'b0;
        vec++; if (bus.scroll_ack !== 1'b1 || bus.busy !== 1'b1) begin err++;
            $display("FAIL %s_accept: got ack=%b busy=%b want 1/1", tag, bus.scroll_ack, bus.busy); end
        step();
        vec++; if (bus.scroll_ack !== 1'b0) begin err++; $display("FAIL %s_ack_pulse: got %b want 0", tag, bus.scroll_ack); end
        while (bus.busy === 1'b1 && n < 20) begin
            n++;
            step();
        end
        gm++;
        vec++; if (n != 5) begin err++; $display("FAIL %s_busy_len: got %0d want 5", tag, n); end
        vec++; if (bus.gen_col !== 16'(gm)) begin err++; $display("FAIL %s_gen_col: got %0d want %0d", tag, bus.gen_col, gm); end
    endtask

    task automatic test_scroll();
        scroll_once("scroll");
        do_read(0, 0, -1);
        do_read(0, 99, -1);
        do_read(2, 99, -1);
        do_read(4, 99, -1);
        step();
    endtask

    task automatic test_write();
        int n = 0;
        vec++; if (bus.wr_ready !== 1'b1) begin err++; $display("FAIL wr_ready_idle: got %b want 1", bus.wr_ready); end
        bus.wr_en = 1'b1; bus.wr_lane = 3'd1; bus.wr_col = 7'd7; bus.wr_state = 3'd3;
`ifdef MAP_RD_BYPASS_EN
        push_read(1, 7, 3);
`else
        push_read(1, 7, -1);
`endif
        step();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        do_read(1, 7, 3);
        do_read(1, 8, -1);
        // Write and scroll in the same cycle: write lands before the regen.
        bus.wr_en = 1'b1; bus.wr_lane = 3'd3; bus.wr_col = 7'd20; bus.wr_state = 3'd5;
        bus.scroll_req = 1'b1;
        step();
        bus.wr_en = 1'b0; bus.scroll_req = 1'b0;
        while (bus.busy === 1'b1 && n < 20) begin n++; step(); end
        gm++;
        vec++; if (bus.gen_col !== 16'(gm)) begin err++; $display("FAIL wr_scroll_gen_col: got %0d want %0d", bus.gen_col, gm); end
        do_read(3, 19, 5);
        do_read(1, 6, 3);
        step();
    endtask

    task automatic test_regen_guard();
        int n = 0;
        bus.scroll_req = 1'b1;
        step();
        bus.scroll_req = 1'b0;
        vec++; if (bus.wr_ready !== 1'b0) begin err++; $display("FAIL regen_wr_ready: got %b want 0", bus.wr_ready); end
        bus.scroll_req = 1'b1;
        do_read(0, 120, -1);
        bus.scroll_req = 1'b0;
        do_read(2, 5, -1);
        while (bus.wr_ready !== 1'b1 && n < 20) begin n++; step(); end
        gm++;
        bus.wr_en = 1'b1; bus.wr_lane = 3'd0; bus.wr_col = 7'd10; bus.wr_state = 3'd6;
        step();
        bus.wr_en = 1'b0;
        repeat (3) step();
        vec++; if (bus.gen_col !== 16'(gm) || bus.busy !== 1'b0) begin err++;
            $display("FAIL regen_second_scroll: got gen_col=%0d busy=%b want %0d/0", bus.gen_col, bus.busy, gm); end
        do_read(0, 10, 6);
        do_read(0, 11, -1);
        step();
    endtask

    task automatic test_back_to_back();
        scroll_once("b2b_a");
        scroll_once("b2b_b");
        do_read(1, 0, -1);
        do_read(3, 50, -1);
        step();
    endtask

    task automatic test_reset_mid_regen();
        bus.scroll_req = 1'b1;
        step();
        bus.scroll_req = 1'b0;
        do_read(0, 5, -1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        mready = 1'b0;
        #1;
        vec++; if (bus.rd_valid !== 1'b0 || {bus.r, bus.g, bus.b, bus.block_state} !== 15'd0) begin err++;
            $display("FAIL midrst_read_clear: got valid=%b data=%h want 0/0", bus.rd_valid, {bus.r, bus.g, bus.b, bus.block_state}); end
        vec++; if (bus.map_ready !== 1'b0 || bus.busy !== 1'b1 || bus.gen_col !== 16'd0) begin err++;
            $display("FAIL midrst_ctrl: got ready=%b busy=%b gen_col=%0d want 0/1/0", bus.map_ready, bus.busy, bus.gen_col); end
        step();
        step();
        run_init("reinit");
        do_read(0, 0, -1);
        do_read(1, 3, -1);
        step();
    endtask

    initial begin
        rst_n          = 1'b1;
        bus.rd_en      = 1'b0;
        bus.rd_lane    = '0;
        bus.rd_col     = '0;
        bus.wr_en      = 1'b0;
        bus.wr_lane    = '0;
        bus.wr_col     = '0;
        bus.wr_state   = '0;
        bus.scroll_req = 1'b0;
        fork
            monitor();
            forever begin
                @(posedge clk);
                cyc++;
            end
        join_none
        #2 rst_n = 1'b0;
        test_reset();
        test_init();
        test_reads();
        test_scroll();
        test_write();
        test_regen_guard();
        test_back_to_back();
        test_reset_mid_regen();
        repeat (3) step();
        vec++;
        if (sb.size() != 0) begin err++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scroll_tile_map.md
Name: scroll_tile_map

Overview:
- Parametrised, scrollable tile-map store for the lane-runner playfield: LANES x COLS cells, each holding 12-bit colour (4/4/4 RGB) plus a STATE_W-bit block state.
- Sequential successor to the fixed combinational lane map.
- Fills itself after reset from per-lane modulo rules and regenerates the departing column on every scroll, so the pattern continues indefinitely.
- The game engine can also overwrite individual block states. The VGA renderer reads through a registered port.

Parameters:
- LANES, 5, number of lanes (rows).
- COLS, 100, visible columns per lane.
- STATE_W, 3, block_state width.
- GCOL_W, 16, width of the global generated-column counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  1  read request
- rd_lane  in  clog2(LANES)  lane index
- rd_col  in  clog2(COLS)  logical column, relative to the scroll base
- rd_valid  out  1  read data valid
- r  out  4  red
- g  out  4  green
- b  out  4  blue
- block_state  out  STATE_W  cell state
- wr_en  in  1  state write request
- wr_ready  out  1  write accepted when high
- wr_lane  in  clog2(LANES)  write lane
- wr_col  in  clog2(COLS)  write logical column
- wr_state  in  STATE_W  new block state
- scroll_req  in  1  advance map by one column
- scroll_ack  out  1  one-cycle pulse when a scroll is accepted
- busy  out  1  INIT or REGEN in progress
- map_ready  out  1  init done
- gen_col  out  GCOL_W  global column index of logical column 0

Behaviour:
- Reset values (async, rst_n low):
  - FSM=INIT; all counters 0; base=0.
  - rd_valid, scroll_ack, wr_ready, map_ready = 0; busy = 1.
  - r/g/b/block_state = 0; gen_col = 0.
- FSM states:
  - INIT: write one cell per cycle, lane-major within column, columns 0..COLS-1. Exits to READY after LANES*COLS cycles.
  - READY: idle; accepts reads, writes and scrolls.
  - REGEN: entered when scroll_req is seen in READY.
    - scroll_ack pulses in the accepting cycle.
    - Physical column `base` is rewritten with global column gen_col+COLS, one lane per cycle, for LANES cycles.
    - On the final cycle: base <= (base+1) mod COLS, gen_col <= gen_col+1 (wraps at 2^GCOL_W), then return to READY.
    - scroll_req outside READY is ignored; it is not queued.
- Cell generation for lane i at generated column g:
  - Colour = PALETTE[i mod 5].
  - State = 0 if g mod MA[i] == OA[i]; else 2 if g mod MB[i] == OB[i]; else 1.
  - Residues are held in per-lane mod counters. No dividers are used.
  - Counters advance once per generated column and keep cycling across gen_col wrap.
- Address mapping: phys = (base + col) mod COLS, computed with a compare/subtract, not `%`.
- Reads:
  - Accepted only when map_ready=1. rd_en while not ready is ignored and rd_valid stays 0.
  - Latency is 1 cycle: rd_valid and data are registered.
  - rd_col>=COLS or rd_lane>=LANES gives rd_valid=1 with all data 0.
  - During REGEN, a read of logical column 0 returns unspecified state; all other columns are valid.
  - Outputs hold their value when rd_valid=0.
- Writes:
  - wr_ready = (FSM==READY).
  - Accepted when wr_en & wr_ready. Only block_state is modified; colour is untouched.
  - Out-of-range addresses are dropped.
  - If a write and scroll_req arrive in the same cycle, the write is performed first, then REGEN starts next cycle.
- Read-during-write to the same cell returns the old data unless MAP_RD_BYPASS_EN is defined.
- Reset asserted mid-REGEN or mid-INIT aborts the operation and restarts INIT after release.

Optional Feature:
- Macro: MAP_RD_BYPASS_EN.
- Defined: a same-cycle accepted write to the cell being read forwards wr_state to block_state on the next cycle.
- Undefined: the old stored state is returned.

Decomposition:
- Package map_pkg holds:
  - PALETTE[5] = {F00, 0F0, 00F, 0FF, F0F}.
  - MA/OA = {3/1, 5/0, 4/2, 6/4, 7/2}.
  - MB/OB = {10/0, 12/3, 8/0, 9/6, 14/4}.
  - State codes: ST_EMPTY=0, ST_BLOCK=1, ST_SPECIAL=2.
  - FSM enum {INIT, READY, REGEN}.
- Sub-module lane_pattern_gen: per-lane residue counters with `advance` and `lane` select inputs, producing the {state, colour} word.

Test Plan:
- Reset, release, count cycles: map_ready rises after exactly 500 cycles; busy is high throughout.
- Read lane0 col0 -> rd_valid next cycle, rgb F/0/0, state 2. Read lane0 col1 -> state 0. Read lane1 col3 -> state 2.
- Pulse scroll_req: scroll_ack for 1 cycle, busy for 5 cycles, then gen_col=1.
  - Read lane0 col0 -> state 0 (global 1).
  - Read lane0 col99 -> state 0 (global 100: 100 mod 3 = 1).
  - Read lane2 col99 -> state 1.
- Write lane1 col7 with state 3, then read it -> 3, colour still 0F0.
  - Same-cycle read returns the old value 1, or 3 with MAP_RD_BYPASS_EN.
- During REGEN: wr_en is held off while wr_ready=0; a second scroll_req is ignored (gen_col advances only 1). Read rd_col=120 -> rd_valid with all zeros.
- Assert rst_n low at REGEN cycle 2: outputs clear immediately and INIT reruns; lane0 col0 reads state 2 again.
